// File: rtl/dlx_id_stage_p.sv
// DLX instruction-decode stage: register file, operand fetch with WB bypass, immediate
// extension, load-use interlock and a one-deep valid/ready ID/EX register.
module dlx_id_stage_p #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 16,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clock2,
  input  logic             reset2,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      npc_in2,
  input  logic [31:0]      inst_in2,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             ex_is_load,
  input  logic [AW-1:0]    ex_rd,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  aout2,
  output logic [XLEN-1:0]  bout2,
  output logic [XLEN-1:0]  imout2,
  output logic [31:0]      irout2,
  output logic [31:0]      npcout2,
  output logic             illegal,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b001010;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_SUBI  = 6'b010010;
  localparam logic [5:0] OP_ANDI  = 6'b010100;
  localparam logic [5:0] OP_ORI   = 6'b010101;
  localparam logic [5:0] OP_XORI  = 6'b010110;
  localparam logic [5:0] OP_BEQZ  = 6'b100000;
  localparam logic [5:0] OP_BNEZ  = 6'b100001;
  localparam logic [5:0] OP_J     = 6'b100100;
  localparam logic [5:0] OP_RTYPE = 6'b110000;

  logic [XLEN-1:0] rf_q [NREGS];

  logic [5:0]      opcode;
  logic [5:0]      func;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            func_legal;
  logic            dec_illegal;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] imm_sext16;
  logic [XLEN-1:0] imm_zext16;
  logic [XLEN-1:0] imm_sext26;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            hazard;
  logic            adv;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  aout_q,      aout_d;
  logic [XLEN-1:0]  bout_q,      bout_d;
  logic [XLEN-1:0]  imm_q,       imm_d;
  logic [31:0]      ir_q,        ir_d;
  logic [31:0]      npc_q,       npc_d;
  logic             illegal_q,   illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign opcode     = inst_in2[31:26];
  assign func       = inst_in2[5:0];
  assign rs1        = inst_in2[21 +: AW];
  assign rs2        = inst_in2[16 +: AW];
  assign imm_sext16 = {{(XLEN-16){inst_in2[15]}}, inst_in2[15:0]};
  assign imm_zext16 = {{(XLEN-16){1'b0}}, inst_in2[15:0]};
  assign imm_sext26 = {{(XLEN-26){inst_in2[25]}}, inst_in2[25:0]};

  always_comb begin
    case (func)
      6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
      6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b010000: func_legal = 1'b1;
      default: func_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_ext     = '0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (opcode)
      OP_LW, OP_ADDI, OP_SUBI, OP_BEQZ, OP_BNEZ,
      6'b011010, 6'b011011, 6'b011100, 6'b011101, 6'b011110, 6'b011111: begin
        imm_ext  = imm_sext16;
        uses_rs1 = 1'b1;
      end
      OP_SW: begin
        imm_ext  = imm_sext16;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        imm_ext  = imm_zext16;
        uses_rs1 = 1'b1;
      end
      OP_J: imm_ext = imm_sext26;
      OP_RTYPE: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        dec_illegal = ~func_legal;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Same-cycle WB write wins over the stored value when bypassing is enabled.
  always_comb begin
    rs1_val = rf_q[rs1];
    if (BYPASS_EN && wb_en && (wb_addr == rs1)) rs1_val = wb_data;
    if (rs1 == '0) rs1_val = '0;
    rs2_val = rf_q[rs2];
    if (BYPASS_EN && wb_en && (wb_addr == rs2)) rs2_val = wb_data;
    if (rs2 == '0) rs2_val = '0;
  end

  assign hazard   = in_valid & ex_is_load & (ex_rd != '0) &
                    (((ex_rd == rs1) & uses_rs1) | ((ex_rd == rs2) & uses_rs2));
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = flush | (adv & ~hazard);

  always_comb begin
    out_valid_d = out_valid_q;
    aout_d      = aout_q;
    bout_d      = bout_q;
    imm_d       = imm_q;
    ir_d        = ir_q;
    npc_d       = npc_q;
    illegal_d   = illegal_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (adv && hazard) begin
      out_valid_d = 1'b0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (adv && in_valid) begin
      out_valid_d = 1'b1;
      aout_d      = rs1_val;
      bout_d      = (uses_rs2 && !dec_illegal) ? rs2_val : '0;
      imm_d       = dec_illegal ? '0 : imm_ext;
      ir_d        = inst_in2;
      npc_d       = npc_in2;
      illegal_d   = dec_illegal;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock2 or negedge reset2) begin
    if (!reset2) begin
      out_valid_q <= 1'b0;
      aout_q      <= '0;
      bout_q      <= '0;
      imm_q       <= '0;
      ir_q        <= '0;
      npc_q       <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      aout_q      <= aout_d;
      bout_q      <= bout_d;
      imm_q       <= imm_d;
      ir_q        <= ir_d;
      npc_q       <= npc_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // r0 is never written, so its entry stays at its reset value of zero.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    always_ff @(posedge clock2 or negedge reset2) begin
      if (!reset2) begin
        rf_q[gi] <= '0;
      end else if (wb_en && (wb_addr != '0) && (wb_addr == AW'(gi))) begin
        rf_q[gi] <= wb_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign aout2     = aout_q;
  assign bout2     = bout_q;
  assign imout2    = imm_q;
  assign irout2    = ir_q;
  assign npcout2   = npc_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_cnt_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule
